// File: rtl/ocm_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// ocm_port_arbiter_if
// Bundle of every signal between the OCM port arbiter and its surroundings:
// the two requester ports (A = Rx sample capture writer, B = host/debug),
// the single-port OCM master side and the busy flag.
//   a_*/b_*  : req, write, addr, byteen, wdata in; gnt, rvalid, rdata out
//   m_*      : address, byteenable, chipselect, write, writedata, clken out;
//              readdata in
//   busy     : access issued this cycle or a read return is pending
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the OCM)
// ----------------------------------------------------------------------------
interface ocm_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  a_req;
    logic                  a_write;
    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W/8-1:0]   a_byteen;
    logic [DATA_W-1:0]     a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_W-1:0]     a_rdata;

    logic                  b_req;
    logic                  b_write;
    logic [ADDR_W-1:0]     b_addr;
    logic [DATA_W/8-1:0]   b_byteen;
    logic [DATA_W-1:0]     b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_W-1:0]     b_rdata;

    logic [ADDR_W-1:0]     m_address;
    logic [DATA_W/8-1:0]   m_byteenable;
    logic                  m_chipselect;
    logic                  m_write;
    logic [DATA_W-1:0]     m_writedata;
    logic                  m_clken;
    logic [DATA_W-1:0]     m_readdata;

    logic                  busy;

    modport slave (
        input  a_req, a_write, a_addr, a_byteen, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_write, b_addr, b_byteen, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata,
        output busy
    );

    modport master (
        output a_req, a_write, a_addr, a_byteen, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_write, b_addr, b_byteen, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata,
        input  busy
    );
endinterface

// File: rtl/ocm_port_arbiter.sv
// ----------------------------------------------------------------------------
// ocm_port_arbiter
// Two-requester arbiter in front of a single-port, 1-cycle-latency OCM.
// Issues at most one access per cycle, grant is combinational from the
// requests and a registered round-robin pointer, and read data is routed
// back to the port that issued the read one cycle after its grant.
// Ports:
//   clk      : single clock shared with the OCM
//   reset_n  : asynchronous active-low reset
//   bus      : ocm_port_arbiter_if.slave (requester ports A/B, OCM m_*, busy)
// Parameters:
//   ADDR_W    : OCM word address width
//   DATA_W    : OCM data width (byte enables are DATA_W/8)
//   FIXED_PRI : 0 = round-robin on ties, 1 = port A always wins ties
// ----------------------------------------------------------------------------
module ocm_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    ocm_port_arbiter_if.slave   bus
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e               last_q,  last_d;
    port_e               owner_q, owner_d;
    logic                pending_q, pending_d;
    logic                clken_q;
    logic [DATA_W-1:0]   a_hold_q, a_hold_d;
    logic [DATA_W-1:0]   b_hold_q, b_hold_d;
    logic                a_gnt, b_gnt;
    logic                a_ret, b_ret;

    // Grants are held off until the first edge after reset release, so that
    // nothing reaches the OCM while it is still clock-disabled.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (clken_q) begin
            if (bus.a_req && bus.b_req) begin
                if (FIXED_PRI || (last_q == PORT_B)) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end else if (bus.a_req) begin
                a_gnt = 1'b1;
            end else if (bus.b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    // OCM request mux; idle cycles drive zeros on every field.
    always_comb begin
        bus.m_address    = '0;
        bus.m_byteenable = '0;
        bus.m_writedata  = '0;
        bus.m_chipselect = 1'b0;
        bus.m_write      = 1'b0;
        if (a_gnt) begin
            bus.m_address    = bus.a_addr;
            bus.m_byteenable = bus.a_byteen;
            bus.m_writedata  = bus.a_wdata;
            bus.m_chipselect = 1'b1;
            bus.m_write      = bus.a_write;
        end else if (b_gnt) begin
            bus.m_address    = bus.b_addr;
            bus.m_byteenable = bus.b_byteen;
            bus.m_writedata  = bus.b_wdata;
            bus.m_chipselect = 1'b1;
            bus.m_write      = bus.b_write;
        end
    end

    // Pointer, read-return tracking and per-port rdata hold registers.
    always_comb begin
        last_d    = last_q;
        owner_d   = owner_q;
        pending_d = 1'b0;
        a_hold_d  = a_hold_q;
        b_hold_d  = b_hold_q;

        if (a_gnt) begin
            last_d    = PORT_A;
            owner_d   = PORT_A;
            pending_d = ~bus.a_write;
        end else if (b_gnt) begin
            last_d    = PORT_B;
            owner_d   = PORT_B;
            pending_d = ~bus.b_write;
        end

        if (a_ret) a_hold_d = bus.m_readdata;
        if (b_ret) b_hold_d = bus.m_readdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= PORT_A;
            owner_q   <= PORT_A;
            pending_q <= 1'b0;
            clken_q   <= 1'b0;
            a_hold_q  <= '0;
            b_hold_q  <= '0;
        end else begin
            last_q    <= last_d;
            owner_q   <= owner_d;
            pending_q <= pending_d;
            clken_q   <= 1'b1;
            a_hold_q  <= a_hold_d;
            b_hold_q  <= b_hold_d;
        end
    end

    // The returning word is passed straight through in the return cycle and
    // then held, so the non-owner's rdata keeps its previous value.
    assign a_ret = pending_q && (owner_q == PORT_A);
    assign b_ret = pending_q && (owner_q == PORT_B);

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_ret;
    assign bus.b_rvalid = b_ret;
    assign bus.a_rdata  = a_ret ? bus.m_readdata : a_hold_q;
    assign bus.b_rdata  = b_ret ? bus.m_readdata : b_hold_q;
    assign bus.m_clken  = clken_q;
    assign bus.busy     = a_gnt | b_gnt | pending_q;

endmodule

// File: tb/tb_ocm_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ocm_port_arbiter
// Directed bench for ocm_port_arbiter. dut0 is round-robin, dut1 fixed
// priority; each has a small 1-cycle-latency byte-enabled OCM model.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_ocm_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk;
    logic rst0_n;
    logic rst1_n;

    int n_total;
    int n_bad;

    ocm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
    ocm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    ocm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRI(1'b0)) dut0 (
        .clk     (clk),
        .reset_n (rst0_n),
        .bus     (bus0)
    );

    ocm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRI(1'b1)) dut1 (
        .clk     (clk),
        .reset_n (rst1_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OCM models
    logic [DATA_W-1:0] mem0 [1024];
    logic [DATA_W-1:0] mem1 [1024];
    logic [DATA_W-1:0] rd0, rd1;

    always @(posedge clk) begin
        if (bus0.m_chipselect && bus0.m_clken) begin
            if (bus0.m_write) begin
                for (int b = 0; b < DATA_W / 8; b++)
                    if (bus0.m_byteenable[b]) mem0[bus0.m_address][8*b +: 8] <= bus0.m_writedata[8*b +: 8];
            end else begin
                rd0 <= mem0[bus0.m_address];
            end
        end
    end

    always @(posedge clk) begin
        if (bus1.m_chipselect && bus1.m_clken) begin
            if (bus1.m_write) begin
                for (int b = 0; b < DATA_W / 8; b++)
                    if (bus1.m_byteenable[b]) mem1[bus1.m_address][8*b +: 8] <= bus1.m_writedata[8*b +: 8];
            end else begin
                rd1 <= mem1[bus1.m_address];
            end
        end
    end

    assign bus0.m_readdata = rd0;
    assign bus1.m_readdata = rd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_a0(input logic req, input logic wr, input logic [9:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        bus0.a_req = req; bus0.a_write = wr; bus0.a_addr = addr;
        bus0.a_byteen = be; bus0.a_wdata = wd;
    endtask

    task automatic set_b0(input logic req, input logic wr, input logic [9:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        bus0.b_req = req; bus0.b_write = wr; bus0.b_addr = addr;
        bus0.b_byteen = be; bus0.b_wdata = wd;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst0_n  = 1'b0;
        rst1_n  = 1'b0;
        set_a0(1'b1, 1'b0, 10'd0, 4'h0, 32'h0);
        set_b0(1'b1, 1'b0, 10'd0, 4'h0, 32'h0);
        bus1.a_req = 1'b0; bus1.a_write = 1'b0; bus1.a_addr = '0; bus1.a_byteen = '0; bus1.a_wdata = '0;
        bus1.b_req = 1'b0; bus1.b_write = 1'b0; bus1.b_addr = '0; bus1.b_byteen = '0; bus1.b_wdata = '0;

        // 1: reset with both requesting
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_gnt",    {31'b0, bus0.a_gnt},        32'd0);
        chk("rst_b_gnt",    {31'b0, bus0.b_gnt},        32'd0);
        chk("rst_a_rvalid", {31'b0, bus0.a_rvalid},     32'd0);
        chk("rst_b_rvalid", {31'b0, bus0.b_rvalid},     32'd0);
        chk("rst_cs",       {31'b0, bus0.m_chipselect}, 32'd0);
        chk("rst_clken",    {31'b0, bus0.m_clken},      32'd0);
        chk("rst_busy",     {31'b0, bus0.busy},         32'd0);
        chk("rst_addr",     {22'b0, bus0.m_address},    32'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_clken", {31'b0, bus0.m_clken}, 32'd1);
        chk("tie1_b_gnt", {31'b0, bus0.b_gnt},  32'd1);
        chk("tie1_a_gnt", {31'b0, bus0.a_gnt},  32'd0);
        @(negedge clk);
        set_a0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        set_b0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        chk("idle_cs", {31'b0, bus0.m_chipselect}, 32'd0);

        // 2: write then read at the top address
        @(negedge clk);
        set_a0(1'b1, 1'b1, 10'h3FF, 4'hF, 32'hDEADBEEF);
        #1;
        chk("wr_a_gnt",  {31'b0, bus0.a_gnt},       32'd1);
        chk("wr_m_addr", {22'b0, bus0.m_address},   32'h3FF);
        chk("wr_m_wr",   {31'b0, bus0.m_write},     32'd1);
        chk("wr_m_data", bus0.m_writedata,          32'hDEADBEEF);
        @(negedge clk);
        set_a0(1'b1, 1'b0, 10'h3FF, 4'h0, 32'h0);
        #1;
        chk("rd_a_gnt", {31'b0, bus0.a_gnt},   32'd1);
        chk("rd_m_wr",  {31'b0, bus0.m_write}, 32'd0);
        @(negedge clk);
        set_a0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        chk("rd_a_rvalid", {31'b0, bus0.a_rvalid}, 32'd1);
        chk("rd_a_rdata",  bus0.a_rdata,           32'hDEADBEEF);
        chk("rd_b_rvalid", {31'b0, bus0.b_rvalid}, 32'd0);
        chk("rd_busy",     {31'b0, bus0.busy},     32'd1);

        // preload addresses 16..31 through port A, back to back
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            set_a0(1'b1, 1'b1, 10'(16 + k), 4'hF, 32'h1000_0010 + 32'(k));
            #1;
            if (k == 0 || k == 15) chk("pre_a_gnt", {31'b0, bus0.a_gnt}, 32'd1);
        end

        // 3: both ports stream 8 reads; B then A alternating
        begin
            int grants;
            grants = 0;
            for (int i = 0; i <= 16; i++) begin
                @(negedge clk);
                if (i < 16) begin
                    set_a0(1'b1, 1'b0, 10'(16 + i / 2), 4'h0, 32'h0);
                    set_b0(1'b1, 1'b0, 10'(24 + (i + 1) / 2), 4'h0, 32'h0);
                end else begin
                    set_a0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
                    set_b0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
                end
                #1;
                if (i < 16) begin
                    chk("rr_a_gnt", {31'b0, bus0.a_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
                    chk("rr_b_gnt", {31'b0, bus0.b_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
                    grants += int'(bus0.a_gnt) + int'(bus0.b_gnt);
                end
                if (i > 0) begin
                    if ((i - 1) % 2 == 0) begin
                        chk("rr_b_rvalid", {31'b0, bus0.b_rvalid}, 32'd1);
                        chk("rr_a_rvalid", {31'b0, bus0.a_rvalid}, 32'd0);
                        chk("rr_b_rdata",  bus0.b_rdata, 32'h1000_0018 + 32'((i - 1) / 2));
                    end else begin
                        chk("rr_a_rvalid", {31'b0, bus0.a_rvalid}, 32'd1);
                        chk("rr_b_rvalid", {31'b0, bus0.b_rvalid}, 32'd0);
                        chk("rr_a_rdata",  bus0.a_rdata, 32'h1000_0010 + 32'((i - 1) / 2));
                    end
                end
            end
            chk("rr_grants", 32'(grants), 32'd16);
            chk("rr_b_hold", bus0.b_rdata, 32'h1000_001F);
        end

        // 5: partial byte write then read back
        @(negedge clk);
        set_a0(1'b1, 1'b1, 10'd5, 4'hF, 32'h11223344);
        @(negedge clk);
        set_a0(1'b1, 1'b1, 10'd5, 4'b0001, 32'h00000055);
        #1;
        chk("be_m_be", {28'b0, bus0.m_byteenable}, 32'h1);
        @(negedge clk);
        set_a0(1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
        @(negedge clk);
        set_a0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        chk("be_rvalid", {31'b0, bus0.a_rvalid}, 32'd1);
        chk("be_rdata",  bus0.a_rdata,           32'h11223355);

        // 4: fixed priority on dut1
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus1.a_req = 1'b1; bus1.a_addr = 10'(i);
            bus1.b_req = 1'b1; bus1.b_addr = 10'd100;
            #1;
            chk("fp_a_gnt", {31'b0, bus1.a_gnt}, 32'd1);
            chk("fp_b_gnt", {31'b0, bus1.b_gnt}, 32'd0);
        end
        @(negedge clk);
        bus1.a_req = 1'b0;
        #1;
        chk("fp_b_after", {31'b0, bus1.b_gnt}, 32'd1);
        chk("fp_a_after", {31'b0, bus1.a_gnt}, 32'd0);
        @(negedge clk);
        bus1.b_req = 1'b0;

        // 6: reset right after a B read grant drops the return
        @(negedge clk);
        set_b0(1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
        #1;
        chk("rr6_b_gnt", {31'b0, bus0.b_gnt}, 32'd1);
        @(posedge clk);
        #1;
        rst0_n = 1'b0;
        set_b0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        chk("rst6_b_rvalid", {31'b0, bus0.b_rvalid}, 32'd0);
        chk("rst6_busy",     {31'b0, bus0.busy},     32'd0);
        chk("rst6_b_rdata",  bus0.b_rdata,           32'd0);
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post6_b_rvalid", {31'b0, bus0.b_rvalid}, 32'd0);
            chk("post6_busy",     {31'b0, bus0.busy},     32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
